biriscv_icache_lite: RTL and testbench



---
 rtl/biriscv_icache_lite_pkg.sv | 29 ++
 rtl/biriscv_icache_lite_ram.sv | 24 ++
 rtl/biriscv_icache_lite.sv | 215 +++++++++++++++++++++
 tb/tb_biriscv_icache_lite.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/biriscv_icache_lite_pkg.sv
// Shared definitions for the direct-mapped instruction cache: state encoding,
// beat width and address-field width helpers.
package biriscv_icache_lite_defs;

    localparam int ADDR_W = 32;
    localparam int BEAT_W = 64;
    localparam int BYTE_OFF_W = 3;

    typedef enum logic [2:0] {
        ST_FLUSH   = 3'd0,
        ST_LOOKUP  = 3'd1,
        ST_MISS    = 3'd2,
        ST_REFILL  = 3'd3,
        ST_RESPOND = 3'd4
    } icache_state_t;

    function automatic int word_w(input int beats_per_line);
        return $clog2(beats_per_line);
    endfunction

    function automatic int index_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_w(input int num_lines, input int beats_per_line);
        return ADDR_W - BYTE_OFF_W - word_w(beats_per_line) - index_w(num_lines);
    endfunction

endpackage

// File: rtl/biriscv_icache_lite_ram.sv
// Single-clock RAM with one write port and one registered read port.
module biriscv_icache_lite_ram #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 256,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             i_clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        o_rd_data <= r_mem[i_rd_addr];
    end

endmodule

// File: rtl/biriscv_icache_lite.sv
// Direct-mapped read-only instruction cache answering 64-bit fetches; misses
// refill a whole line from a burst read port.
module biriscv_icache_lite
    import biriscv_icache_lite_defs::*;
#(
    parameter int NUM_LINES      = 64,
    parameter int BEATS_PER_LINE = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_rd_i,
    input  logic              req_flush_i,
    input  logic              req_invalidate_i,
    input  logic [31:0]       req_pc_i,
    output logic              req_accept_o,
    output logic              req_valid_o,
    output logic              req_error_o,
    output logic [BEAT_W-1:0] req_inst_o,
    output logic              mem_rd_o,
    output logic [31:0]       mem_addr_o,
    input  logic              mem_accept_i,
    input  logic              mem_valid_i,
    input  logic              mem_error_i,
    input  logic [BEAT_W-1:0] mem_data_i
);

    localparam int W       = word_w(BEATS_PER_LINE);
    localparam int IDX_W   = index_w(NUM_LINES);
    localparam int TAG_W   = tag_w(NUM_LINES, BEATS_PER_LINE);
    localparam int IDX_LSB = BYTE_OFF_W + W;
    localparam int TAG_LSB = IDX_LSB + IDX_W;
    localparam int DATA_AW = IDX_W + W;

    icache_state_t r_state;
    icache_state_t w_next_state;

    logic [IDX_W-1:0]          r_flush_cnt;
    logic [NUM_LINES-1:0]      r_valid;
    logic                      r_lookup_pend;
    logic                      r_flush_pending;
    logic                      r_err;
    logic [W-1:0]              r_beat_cnt;
    logic [BEAT_W-1:0]         r_resp_data;
    logic [ADDR_W-1:BYTE_OFF_W] r_req_pc;

    logic [IDX_W-1:0]  w_req_idx;
    logic [W-1:0]      w_req_word;
    logic [IDX_W-1:0]  w_lat_idx;
    logic [W-1:0]      w_lat_word;
    logic [TAG_W-1:0]  w_lat_tag;
    logic [TAG_W-1:0]  w_tag_rd;
    logic [BEAT_W-1:0] w_data_rd;
    logic              w_hit;
    logic              w_miss_now;
    logic              w_can_accept;
    logic              w_rd_take;
    logic              w_inval_take;
    logic              w_beat_take;
    logic              w_last_beat;
    logic              w_unused_pc;

    assign w_req_idx   = req_pc_i[IDX_LSB +: IDX_W];
    assign w_req_word  = req_pc_i[BYTE_OFF_W +: W];
    assign w_lat_idx   = r_req_pc[IDX_LSB +: IDX_W];
    assign w_lat_word  = r_req_pc[BYTE_OFF_W +: W];
    assign w_lat_tag   = r_req_pc[ADDR_W-1:TAG_LSB];
    assign w_unused_pc = ^req_pc_i[BYTE_OFF_W-1:0];

    // Lookup result is resolved one cycle after accept, against the latched pc.
    assign w_hit      = r_lookup_pend && r_valid[w_lat_idx] && (w_tag_rd == w_lat_tag);
    assign w_miss_now = r_lookup_pend && !w_hit;

    // A flush seen in LOOKUP blocks new accepts so no response is orphaned.
    assign w_can_accept = (r_state == ST_LOOKUP) && !w_miss_now
                          && !r_flush_pending && !req_flush_i;
    assign w_inval_take = w_can_accept && req_invalidate_i;
    assign w_rd_take    = w_can_accept && req_rd_i && !req_invalidate_i;
    assign req_accept_o = w_can_accept && !(req_rd_i && req_invalidate_i);

    assign w_beat_take = (r_state == ST_REFILL) && mem_valid_i;
    assign w_last_beat = w_beat_take && (r_beat_cnt == W'(BEATS_PER_LINE - 1));

    biriscv_icache_lite_ram #(
        .WIDTH (TAG_W),
        .DEPTH (NUM_LINES),
        .AW    (IDX_W)
    ) u_tag_ram (
        .i_clk     (clk_i),
        .i_wr_en   (w_last_beat),
        .i_wr_addr (w_lat_idx),
        .i_wr_data (w_lat_tag),
        .i_rd_addr (w_req_idx),
        .o_rd_data (w_tag_rd)
    );

    biriscv_icache_lite_ram #(
        .WIDTH (BEAT_W),
        .DEPTH (NUM_LINES * BEATS_PER_LINE),
        .AW    (DATA_AW)
    ) u_data_ram (
        .i_clk     (clk_i),
        .i_wr_en   (w_beat_take),
        .i_wr_addr ({w_lat_idx, r_beat_cnt}),
        .i_wr_data (mem_data_i),
        .i_rd_addr ({w_req_idx, w_req_word}),
        .o_rd_data (w_data_rd)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_FLUSH: begin
                if (!req_flush_i && (r_flush_cnt == IDX_W'(NUM_LINES - 1))) begin
                    w_next_state = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (w_miss_now) begin
                    w_next_state = ST_MISS;
                end else if (req_flush_i) begin
                    w_next_state = ST_FLUSH;
                end
            end
            ST_MISS: begin
                if (mem_accept_i) begin
                    w_next_state = ST_REFILL;
                end
            end
            ST_REFILL: begin
                if (w_last_beat) begin
                    w_next_state = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                w_next_state = (r_flush_pending || req_flush_i) ? ST_FLUSH : ST_LOOKUP;
            end
            default: w_next_state = ST_FLUSH;
        endcase
    end

    always_comb begin
        req_valid_o = 1'b0;
        req_error_o = 1'b0;
        req_inst_o  = '0;
        mem_rd_o    = 1'b0;
        mem_addr_o  = '0;
        if (r_state == ST_RESPOND) begin
            req_valid_o = 1'b1;
            req_error_o = r_err;
            req_inst_o  = r_err ? '0 : r_resp_data;
        end else if (w_hit) begin
            req_valid_o = 1'b1;
            req_inst_o  = w_data_rd;
        end
        if (r_state == ST_MISS) begin
            mem_rd_o   = 1'b1;
            mem_addr_o = {w_lat_tag, w_lat_idx, {(W + BYTE_OFF_W){1'b0}}};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state         <= ST_FLUSH;
            r_flush_cnt     <= '0;
            r_valid         <= '0;
            r_lookup_pend   <= 1'b0;
            r_flush_pending <= 1'b0;
            r_err           <= 1'b0;
            r_beat_cnt      <= '0;
            r_resp_data     <= '0;
            r_req_pc        <= '0;
        end else begin
            r_state       <= w_next_state;
            r_lookup_pend <= w_rd_take;

            if (w_rd_take) begin
                r_req_pc <= req_pc_i[ADDR_W-1:BYTE_OFF_W];
            end
            if (w_inval_take) begin
                r_valid[w_req_idx] <= 1'b0;
            end

            if (r_state == ST_FLUSH) begin
                r_valid[r_flush_cnt] <= 1'b0;
                r_flush_cnt <= req_flush_i ? '0 : r_flush_cnt + IDX_W'(1);
            end

            if (r_state == ST_RESPOND) begin
                r_flush_pending <= 1'b0;
            end else if (req_flush_i && ((r_state == ST_MISS) || (r_state == ST_REFILL)
                                         || ((r_state == ST_LOOKUP) && w_miss_now))) begin
                r_flush_pending <= 1'b1;
            end

            // An errored beat anywhere in the line leaves it invalid.
            if (w_beat_take) begin
                r_beat_cnt <= r_beat_cnt + W'(1);
                if (r_beat_cnt == w_lat_word) begin
                    r_resp_data <= mem_data_i;
                end
                if (mem_error_i) begin
                    r_err <= 1'b1;
                end
                if (w_last_beat) begin
                    r_valid[w_lat_idx] <= !(r_err || mem_error_i);
                end
            end

            if (r_state == ST_RESPOND) begin
                r_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_biriscv_icache_lite.sv
// Randomized self-checking bench for biriscv_icache_lite against a line-level
// cache model (valid/tag per index) and an address-hash backing memory.
module tb_biriscv_icache_lite;

    localparam int LIMIT = 400;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_rd_i, req_flush_i, req_invalidate_i;
    logic [31:0] req_pc_i;
    logic        req_accept_o, req_valid_o, req_error_o;
    logic [63:0] req_inst_o;
    logic        mem_rd_o;
    logic [31:0] mem_addr_o;
    logic        mem_accept_i, mem_valid_i, mem_error_i;
    logic [63:0] mem_data_i;

    int n_cmp = 0;
    int n_err = 0;

    logic        mv [64];
    logic [20:0] mt [64];

    biriscv_icache_lite dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .req_rd_i         (req_rd_i),
        .req_flush_i      (req_flush_i),
        .req_invalidate_i (req_invalidate_i),
        .req_pc_i         (req_pc_i),
        .req_accept_o     (req_accept_o),
        .req_valid_o      (req_valid_o),
        .req_error_o      (req_error_o),
        .req_inst_o       (req_inst_o),
        .mem_rd_o         (mem_rd_o),
        .mem_addr_o       (mem_addr_o),
        .mem_accept_i     (mem_accept_i),
        .mem_valid_i      (mem_valid_i),
        .mem_error_i      (mem_error_i),
        .mem_data_i       (mem_data_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        return {a ^ 32'h5A5A_1234, ~a + 32'd7};
    endfunction

    function automatic int line_idx(input logic [31:0] a);
        return int'((a / 32) % 64);
    endfunction

    function automatic logic [20:0] line_tag(input logic [31:0] a);
        return 21'(a / 2048);
    endfunction

    function automatic logic model_hit(input logic [31:0] a);
        return mv[line_idx(a)] && (mt[line_idx(a)] == line_tag(a));
    endfunction

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_accept(input string tag);
        int n = 0;
        while (!req_accept_o && n < LIMIT) begin
            step();
            n++;
        end
        chk(tag, 64'(n < LIMIT), 64'd1);
    endtask

    task automatic refill(input logic [31:0] addr, input int err_beat, input int flush_beat);
        logic [31:0] base;
        int n = 0;
        int dly;
        base = addr & ~32'h1F;
        while (!mem_rd_o && n < LIMIT) begin
            step();
            n++;
        end
        chk("mem_rd_wait", 64'(n < LIMIT), 64'd1);
        chk("mem_addr", 64'(mem_addr_o), 64'(base));
        dly = $urandom_range(0, 2);
        repeat (dly) step();
        chk("mem_addr_hold", 64'({mem_rd_o, mem_addr_o}), 64'({1'b1, base}));
        mem_accept_i = 1'b1;
        step();
        mem_accept_i = 1'b0;
        for (int b = 0; b < 4; b++) begin
            dly = $urandom_range(0, 2);
            repeat (dly) step();
            mem_valid_i = 1'b1;
            mem_data_i  = mem_word(base + 32'(8 * b));
            mem_error_i = (b == err_beat);
            req_flush_i = (b == flush_beat);
            step();
            mem_valid_i = 1'b0;
            mem_error_i = 1'b0;
            req_flush_i = 1'b0;
        end
        chk("refill_valid", 64'(req_valid_o), 64'd1);
        chk("refill_error", 64'(req_error_o), 64'(err_beat >= 0));
        chk("refill_inst", req_inst_o, (err_beat >= 0) ? 64'd0 : mem_word(addr & ~32'h7));
        mv[line_idx(addr)] = (err_beat < 0);
        mt[line_idx(addr)] = line_tag(addr);
        if (flush_beat >= 0) begin
            for (int i = 0; i < 64; i++) mv[i] = 1'b0;
        end
    endtask

    task automatic fetch(input logic [31:0] addr, input int err_beat, input int flush_beat);
        logic hit;
        req_pc_i = addr;
        req_rd_i = 1'b1;
        wait_accept("fetch_accept_wait");
        hit = model_hit(addr);
        step();
        req_rd_i = 1'b0;
        chk("lookup_valid", 64'(req_valid_o), 64'(hit));
        if (hit) begin
            chk("hit_inst", req_inst_o, mem_word(addr & ~32'h7));
            chk("hit_no_memrd", 64'(mem_rd_o), 64'd0);
        end else begin
            chk("miss_accept", 64'(req_accept_o), 64'd0);
            refill(addr, err_beat, flush_beat);
        end
    endtask

    task automatic burst(input logic [31:0] base);
        req_pc_i = base;
        req_rd_i = 1'b1;
        wait_accept("burst_accept_wait");
        for (int b = 0; b < 4; b++) begin
            step();
            chk("burst_valid", 64'(req_valid_o), 64'(model_hit(base + 32'(8 * b))));
            chk("burst_inst", req_inst_o, mem_word(base + 32'(8 * b)));
            if (b < 3) begin
                chk("burst_accept", 64'(req_accept_o), 64'd1);
                req_pc_i = base + 32'(8 * (b + 1));
            end
        end
        req_rd_i = 1'b0;
    endtask

    task automatic invalidate(input logic [31:0] addr);
        req_pc_i         = addr;
        req_invalidate_i = 1'b1;
        wait_accept("inval_accept_wait");
        step();
        req_invalidate_i = 1'b0;
        chk("inval_no_resp", 64'(req_valid_o), 64'd0);
        mv[line_idx(addr)] = 1'b0;
    endtask

    task automatic count_flush(input string tag);
        int n = 0;
        logic saw_rd = 1'b0;
        while (!req_accept_o && n < LIMIT) begin
            saw_rd |= mem_rd_o;
            step();
            n++;
        end
        chk(tag, 64'(n), 64'd64);
        chk({tag, "_memrd"}, 64'(saw_rd), 64'd0);
    endtask

    logic [31:0] pool [6];

    initial begin
        pool[0] = 32'h8000_0000; pool[1] = 32'h8000_0800; pool[2] = 32'h8000_1000;
        pool[3] = 32'h8000_0020; pool[4] = 32'h8000_3020; pool[5] = 32'h8000_07E0;
        for (int i = 0; i < 64; i++) begin
            mv[i] = 1'b0;
            mt[i] = '0;
        end
        rst_i = 1'b1;
        req_rd_i = 1'b0; req_flush_i = 1'b0; req_invalidate_i = 1'b0; req_pc_i = '0;
        mem_accept_i = 1'b0; mem_valid_i = 1'b0; mem_error_i = 1'b0; mem_data_i = '0;
        repeat (3) step();
        chk("rst_outputs",
            64'({req_accept_o, req_valid_o, req_error_o, mem_rd_o, mem_addr_o}), 64'd0);
        chk("rst_inst", req_inst_o, 64'd0);
        rst_i = 1'b0;
        count_flush("reset_flush_cycles");

        fetch(32'h8000_0008, -1, -1);
        fetch(32'h8000_0008, -1, -1);
        burst(32'h8000_0000);

        fetch(32'h8000_0800, -1, -1);
        fetch(32'h8000_0000, -1, -1);

        fetch(32'h8000_1000, 2, -1);
        fetch(32'h8000_1000, -1, -1);

        fetch(32'h8000_0008, -1, -1);
        fetch(32'h8000_0020, -1, 1);
        step();
        count_flush("flush_cycles");
        fetch(32'h8000_0008, -1, -1);

        fetch(32'h8000_0010, -1, -1);
        invalidate(32'h8000_0000);
        fetch(32'h8000_0018, -1, -1);

        for (int it = 0; it < 40; it++) begin
            logic [31:0] a;
            int eb;
            a  = pool[$urandom_range(0, 5)] + 32'(8 * $urandom_range(0, 3));
            eb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
            if ($urandom_range(0, 7) == 0) invalidate(a);
            else fetch(a, eb, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
